// File: rtl/dice_display_mux_if.sv
// dice_display_mux_if: load handshake, scan controls and display outputs of dice_display_mux
interface dice_display_mux_if #(
   parameter int N_DIGITS = 2
);
   logic                  load;
   logic [4*N_DIGITS-1:0] values;
   logic [N_DIGITS-1:0]   digit_en;
   logic [N_DIGITS-1:0]   blink;
   logic                  ready;
   logic [6:0]            seg;
   logic [N_DIGITS-1:0]   an;
   logic                  frame_tick;
   modport master (output load, values, digit_en, blink, input ready, seg, an, frame_tick);
   modport slave (input load, values, digit_en, blink, output ready, seg, an, frame_tick);
endinterface

// File: rtl/dice_display_mux.sv
// dice_display_mux: multiplexed 7-segment scan driver with frame-synchronous value loading
// Defining DICE_DISP_BLINK_EN adds per-digit blinking driven by a frame counter.
module dice_display_mux #(
   parameter int N_DIGITS     = 2,
   parameter int REFRESH_DIV  = 50000,
   parameter int BLINK_FRAMES = 64
) (
   input logic               clk,
   input logic               reset,
   dice_display_mux_if.slave bus
);
   localparam int CW = $clog2(REFRESH_DIV);
   localparam int IW = N_DIGITS > 1 ? $clog2(N_DIGITS) : 1;
   logic [CW-1:0]         cnt_q, cnt_d;
   logic [IW-1:0]         idx_q, idx_d;
   logic [4*N_DIGITS-1:0] shadow_q, shadow_d, pend_q, pend_d;
   logic                  pflag_q, pflag_d, ready_q, tick_q;
   logic [6:0]            seg_q, seg_d;
   logic [N_DIGITS-1:0]   an_q, an_d;
   logic                  step, wrap, accept, blank;
   logic [3:0]            code;

   function automatic logic [6:0] dec(input logic [3:0] c);
      case (c)
         4'd0:    dec = 7'b1000000;
         4'd1:    dec = 7'b1111001;
         4'd2:    dec = 7'b0100100;
         4'd3:    dec = 7'b0110000;
         4'd4:    dec = 7'b0011001;
         4'd5:    dec = 7'b0010010;
         4'd6:    dec = 7'b0000010;
         4'd7:    dec = 7'b1111000;
         4'd8:    dec = 7'b0000000;
         4'd9:    dec = 7'b0010000;
         default: dec = 7'b1111111;
      endcase
   endfunction

`ifdef DICE_DISP_BLINK_EN
   localparam int FW = $clog2(BLINK_FRAMES + 1);
   logic [FW-1:0] fcnt_q;
   logic          phase_q;
   always_ff @(posedge clk) begin
      if (reset) begin
         fcnt_q  <= '0;
         phase_q <= 1'b0;
      end else if (wrap) begin
         fcnt_q  <= fcnt_q == FW'(BLINK_FRAMES - 1) ? '0 : fcnt_q + 1'b1;
         phase_q <= fcnt_q == FW'(BLINK_FRAMES - 1) ? ~phase_q : phase_q;
      end
   end
   assign blank = phase_q & bus.blink[idx_q];
`else
   assign blank = 1'b0;
`endif

   // A load taken on a wrap edge sees pflag_q low, so it waits for the next wrap.
   always_comb begin
      step     = cnt_q == CW'(REFRESH_DIV - 1);
      wrap     = step && idx_q == IW'(N_DIGITS - 1);
      accept   = bus.load && ready_q;
      cnt_d    = step ? '0 : cnt_q + 1'b1;
      idx_d    = wrap ? '0 : step ? idx_q + 1'b1 : idx_q;
      shadow_d = wrap && pflag_q ? pend_q : shadow_q;
      pend_d   = accept ? bus.values : pend_q;
      pflag_d  = accept | (pflag_q & ~wrap);
      code     = shadow_q[idx_q*4 +: 4];
      seg_d    = blank ? 7'h7F : dec(code);
      an_d     = bus.digit_en[idx_q] ? ~(N_DIGITS'(1) << idx_q) : '1;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         cnt_q    <= '0;
         idx_q    <= '0;
         shadow_q <= '1;
         pend_q   <= '1;
         pflag_q  <= 1'b0;
         ready_q  <= 1'b0;
         tick_q   <= 1'b0;
         seg_q    <= 7'h7F;
         an_q     <= '1;
      end else begin
         cnt_q    <= cnt_d;
         idx_q    <= idx_d;
         shadow_q <= shadow_d;
         pend_q   <= pend_d;
         pflag_q  <= pflag_d;
         ready_q  <= ~pflag_d;
         tick_q   <= wrap;
         seg_q    <= seg_d;
         an_q     <= an_d;
      end
   end

   assign bus.ready      = ready_q;
   assign bus.seg        = seg_q;
   assign bus.an         = an_q;
   assign bus.frame_tick = tick_q;
endmodule

// File: tb/tb_dice_display_mux.sv
// tb_dice_display_mux: directed checks of scan timing, load handshake, enables and blink
module tb_dice_display_mux;
   localparam int N = 2;
   logic clk = 1'b0;
   logic reset = 1'b1;
   int   cyc = 0, tbase = 0, n_vec = 0, n_bad = 0;
`ifdef DICE_DISP_BLINK_EN
   localparam logic [6:0] BL7 = 7'b1111111;
`else
   localparam logic [6:0] BL7 = 7'b1111000;
`endif

   dice_display_mux_if #(.N_DIGITS(N)) bus ();
   dice_display_mux #(.N_DIGITS(N), .REFRESH_DIV(4), .BLINK_FRAMES(2)) dut (
      .clk(clk),
      .reset(reset),
      .bus(bus)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s @cyc %0d: got %0h expected %0h", tag, cyc, got, exp);
      end
   endtask

   // frame_tick must pulse every 8 cycles, counted from the last reset edge
   task automatic step1();
      logic rs;
      @(posedge clk);
      rs = reset;
      cyc++;
      if (rs) tbase = cyc;
      #1;
      chk("frame_tick", {31'd0, bus.frame_tick}, {31'd0, !rs && cyc > tbase && (cyc - tbase) % 8 == 0});
   endtask

   task automatic run_to(input int n);
      while (cyc < n) step1();
   endtask

   task automatic chk_disp(input string tag, input logic [6:0] s, input logic [1:0] a);
      chk({tag, "_seg"}, {25'd0, bus.seg}, {25'd0, s});
      chk({tag, "_an"}, {30'd0, bus.an}, {30'd0, a});
   endtask

   initial begin
      bus.load     = 1'b0;
      bus.values   = '0;
      bus.digit_en = 2'b11;
      bus.blink    = 2'b00;
      run_to(1);
      chk_disp("rst1", 7'h7F, 2'b11);
      chk("rst1_ready", {31'd0, bus.ready}, 32'd0);
      run_to(3);
      chk_disp("rst3", 7'h7F, 2'b11);
      chk("rst3_ready", {31'd0, bus.ready}, 32'd0);
      reset = 1'b0;
      run_to(4);
      chk("post_rst_ready", {31'd0, bus.ready}, 32'd1);
      bus.load   = 1'b1;
      bus.values = 8'h61;
      run_to(5);
      chk("accept_ready", {31'd0, bus.ready}, 32'd0);
      bus.values = 8'h34;
      run_to(8);
      bus.load = 1'b0;
      run_to(10);
      chk("busy_ready", {31'd0, bus.ready}, 32'd0);
      run_to(11);
      chk("wrap_ready", {31'd0, bus.ready}, 32'd1);
      run_to(12);
      chk_disp("d0_one", 7'b1111001, 2'b10);
      run_to(16);
      chk_disp("d1_six", 7'b0000010, 2'b01);
      run_to(20);
      chk_disp("ignore34", 7'b1111001, 2'b10);
      run_to(26);
      bus.load   = 1'b1;
      bus.values = 8'h25;
      run_to(27);
      bus.load = 1'b0;
      chk("wrapload_ready", {31'd0, bus.ready}, 32'd0);
      run_to(28);
      chk_disp("wrapload_d0_old", 7'b1111001, 2'b10);
      run_to(32);
      chk_disp("wrapload_d1_old", 7'b0000010, 2'b01);
      run_to(34);
      chk("wrapload_busy", {31'd0, bus.ready}, 32'd0);
      run_to(35);
      chk("wrapload_ready2", {31'd0, bus.ready}, 32'd1);
      run_to(36);
      chk_disp("d0_five", 7'b0010010, 2'b10);
      bus.load     = 1'b1;
      bus.values   = 8'h3C;
      bus.digit_en = 2'b01;
      run_to(37);
      bus.load = 1'b0;
      run_to(40);
      chk_disp("d1_two_dis", 7'b0100100, 2'b11);
      run_to(44);
      chk_disp("d0_code_c", 7'h7F, 2'b10);
      run_to(48);
      chk_disp("d1_three_dis", 7'b0110000, 2'b11);
      bus.digit_en = 2'b11;
      bus.blink    = 2'b10;
      bus.load     = 1'b1;
      bus.values   = 8'h78;
      run_to(49);
      bus.load = 1'b0;
      run_to(52);
      chk_disp("blink_d0_f7", 7'b0000000, 2'b10);
      run_to(56);
      chk_disp("blink_d1_f7", BL7, 2'b01);
      run_to(64);
      chk_disp("blink_d1_f8", BL7, 2'b01);
      run_to(72);
      chk_disp("blink_d1_f9", 7'b1111000, 2'b01);
      bus.load   = 1'b1;
      bus.values = 8'h99;
      run_to(73);
      bus.load = 1'b0;
      chk("preload_ready", {31'd0, bus.ready}, 32'd0);
      reset = 1'b1;
      run_to(74);
      chk_disp("midrst", 7'h7F, 2'b11);
      chk("midrst_ready", {31'd0, bus.ready}, 32'd0);
      reset = 1'b0;
      run_to(75);
      chk("midrst_ready2", {31'd0, bus.ready}, 32'd1);
      run_to(83);
      chk_disp("discarded", 7'h7F, 2'b10);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end
endmodule

// File: doc/dice_display_mux.md
DICE_DISPLAY_MUX -- requirements
Module: dice_display_mux

Interface
REQ-001 SHALL provide parameter N_DIGITS, default 2, the number of multiplexed digits (legal range 1..8).
REQ-002 SHALL provide parameter REFRESH_DIV, default 50000, the number of clk cycles each digit is held active (legal minimum 2).
REQ-003 SHALL provide parameter BLINK_FRAMES, default 64, the number of scan frames per blink half-period.
REQ-004 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-005 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-006 SHALL have port load, input, 1 bit: request to capture values.
REQ-007 SHALL have port values, input, 4*N_DIGITS bits: per-digit codes; digit k occupies bits [4k+3:4k].
REQ-008 SHALL have port digit_en, input, N_DIGITS bits: per-digit enable; a 0 suppresses that digit's anode.
REQ-009 SHALL have port blink, input, N_DIGITS bits: per-digit blink request (used only under REQ-027).
REQ-010 SHALL have port ready, output, 1 bit: high when a load is accepted.
REQ-011 SHALL have port seg, output, 7 bits: active-low segments, with bit 0 = a through bit 6 = g.
REQ-012 SHALL have port an, output, N_DIGITS bits: active-low, one-hot anode select.
REQ-013 SHALL have port frame_tick, output, 1 bit: single-cycle pulse at the end of each scan frame.

Function
REQ-014 SHALL run a refresh counter 0..REFRESH_DIV-1; at the terminal count the counter returns to 0 and the digit index advances by 1.
REQ-015 SHALL wrap the digit index from N_DIGITS-1 to 0; frame_tick SHALL be high for exactly the cycle after this wrap.
REQ-016 SHALL register seg and an: both reflect the new digit index one cycle after the index changes.
REQ-017 SHALL drive an = ~(1<<idx) when digit_en[idx]=1; otherwise an SHALL be all ones.
REQ-018 SHALL decode the displayed digit code as follows (seg, g..a): 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000; codes 10..15 SHALL give 1111111 (blank).
REQ-019 SHALL accept a load when load=1 and ready=1: values are captured into a pending register and ready is 0 from the next cycle.
REQ-020 SHALL ignore load while ready=0; the pending contents are unchanged.
REQ-021 SHALL copy the pending register to the display shadow register in the cycle the digit index wraps, so no frame ever shows mixed old and new values.
REQ-022 SHALL raise ready in the cycle after the shadow copy.
REQ-023 SHALL NOT transfer a load accepted in the same cycle as a wrap on that wrap; it SHALL be transferred on the following wrap.
REQ-024 SHALL NOT change the scan or blink timing in response to digit_en or blink changes; these inputs are sampled live every cycle.

Reset
REQ-025 SHALL, while reset=1, set: counter=0, idx=0, shadow and pending codes=4'hF, pending flag=0, seg=7'b1111111, an=all ones, frame_tick=0, ready=0.
REQ-026 SHALL set ready=1 in the first cycle after reset deasserts, and SHALL discard any in-progress pending load on a reset asserted mid-operation.

Configuration
REQ-027 SHALL include the blink feature when DICE_DISP_BLINK_EN is defined: a frame counter toggles a blink phase every BLINK_FRAMES frame_ticks (phase=0 after reset); while phase=1, digits with blink[idx]=1 SHALL output seg=1111111 with an unchanged.
REQ-028 SHALL, without DICE_DISP_BLINK_EN, omit the frame counter and phase logic entirely and ignore the blink input; all other behaviour is unchanged.

Verification (N_DIGITS=2, REFRESH_DIV=4, BLINK_FRAMES=2)
REQ-029 SHALL cover: reset held 3 cycles, then released -> seg=1111111, an=11 during reset; ready=1 on the first post-reset cycle; frame_tick period = 8 cycles.
REQ-030 SHALL cover: load with values=8'h61 -> after the next wrap, digit0 shows seg=1111001 with an=10 and digit1 shows seg=0000010 with an=01; ready returns to 1 one cycle after the wrap.
REQ-031 SHALL cover: a second load with 8'h34 while ready=0 -> ignored; the display stays 6/1.
REQ-032 SHALL cover: load asserted in the same cycle as a wrap -> the new values appear only after the following wrap (8 cycles later).
REQ-033 SHALL cover: digit_en=2'b01 and code 4'hC on digit0 -> an stays 11 during the digit1 slot; digit0 shows seg=1111111.
REQ-034 SHALL cover: with DICE_DISP_BLINK_EN defined and blink=2'b10 -> digit1 is blanked during frames 3-4, 7-8, ... while digit0 is unaffected; with the macro undefined, no blanking occurs.
